// File: rtl/breg_ctl.sv
// breg_ctl: round-robin sequencer that shares breg's single read and write port
// between two requesters and runs READ, SET, XOR and in-place XOR-SWAP commands.
`ifndef BITNESS
`define BITNESS 8
`endif
`ifndef WORD
`define WORD [`BITNESS-1:0]
`endif

module breg_ctl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic `WORD val0,
  input  logic `WORD val1,
  output logic       ack0,
  output logic       ack1,
  output logic `WORD rdata,
  output logic       err,
  output logic [3:0] breg_ra,
  input  logic `WORD breg_rval,
  output logic       breg_w,
  output logic       breg_y,
  output logic [3:0] breg_wa,
  output logic `WORD breg_wval
);

  typedef enum logic [2:0] {IDLE, EX1, EX2, EX3, ACK} state_t;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_SET = 2'd1, OP_XOR = 2'd2, OP_SWAP = 2'd3} op_t;

  state_t     state, state_nx;

  logic       prio;
  logic       gnt_any;
  logic       gnt_port;
  op_t        gnt_op;
  logic [3:0] gnt_a;
  logic [3:0] gnt_b;
  logic `WORD gnt_val;
  logic       gnt_illegal;
  logic       rsp_port;

  logic       c_port;
  op_t        c_op;
  logic [3:0] c_a;
  logic [3:0] c_b;
  logic `WORD c_val;

  // Arbitration: a lone request wins outright, a tie goes to the port in prio.
  always_comb begin
    gnt_any     = req0 | req1;
    gnt_port    = (req0 && req1) ? prio : req1;
    gnt_op      = op_t'(gnt_port ? op1 : op0);
    gnt_a       = gnt_port ? a1 : a0;
    gnt_b       = gnt_port ? b1 : b0;
    gnt_val     = gnt_port ? val1 : val0;
    gnt_illegal = (gnt_op == OP_SWAP) && ((gnt_a == gnt_b) || ((gnt_a ^ gnt_b) == 4'h8));
    rsp_port    = (state == IDLE) ? gnt_port : c_port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nx = gnt_illegal ? ACK : EX1;
        end
      end
      EX1:     state_nx = (c_op == OP_SWAP) ? EX2 : ACK;
      EX2:     state_nx = EX3;
      EX3:     state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command registers and round-robin pointer are loaded only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio   <= 1'b0;
      c_port <= 1'b0;
      c_op   <= OP_READ;
      c_a    <= 4'd0;
      c_b    <= 4'd0;
      c_val  <= '0;
    end else if (state == IDLE && gnt_any) begin
      prio   <= ~gnt_port;
      c_port <= gnt_port;
      c_op   <= gnt_op;
      c_a    <= gnt_a;
      c_b    <= gnt_b;
      c_val  <= gnt_val;
    end
  end

  // Registered responses; err can only arise from a rejected SWAP straight out of IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack0 <= (state_nx == ACK) && !rsp_port;
      ack1 <= (state_nx == ACK) && rsp_port;
      err  <= (state == IDLE) && (state_nx == ACK);
      if (state == EX1 && c_op == OP_READ) begin
        rdata <= breg_rval;
      end
    end
  end

  // breg port decode; outside write cycles the latched fields are simply held.
  always_comb begin
    breg_ra   = c_a;
    breg_wa   = c_a;
    breg_y    = (c_op == OP_SET);
    breg_wval = c_val;
    breg_w    = 1'b0;
    case (state)
      EX1: begin
        case (c_op)
          OP_READ: begin
            breg_ra = c_a;
          end
          OP_SET: begin
            breg_w    = 1'b1;
            breg_y    = 1'b1;
            breg_wa   = c_a;
            breg_wval = c_val;
          end
          OP_XOR: begin
            breg_w    = 1'b1;
            breg_y    = 1'b0;
            breg_wa   = c_a;
            breg_wval = c_val;
          end
          OP_SWAP: begin
            breg_ra   = c_b;
            breg_wa   = c_a;
            breg_w    = 1'b1;
            breg_y    = 1'b0;
            breg_wval = breg_rval;
          end
          default: begin
            breg_w = 1'b0;
          end
        endcase
      end
      EX2: begin
        breg_ra   = c_a;
        breg_wa   = c_b;
        breg_w    = 1'b1;
        breg_y    = 1'b0;
        breg_wval = breg_rval;
      end
      EX3: begin
        breg_ra   = c_b;
        breg_wa   = c_a;
        breg_w    = 1'b1;
        breg_y    = 1'b0;
        breg_wval = breg_rval;
      end
      default: begin
        breg_w = 1'b0;
      end
    endcase
  end

  a_one_ack: assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
  a_err_with_ack: assert property (@(posedge clk) disable iff (rst) err |-> (ack0 || ack1));

endmodule

// File: tb/tb_breg_ctl.sv
// tb_breg_ctl: directed vector bench for breg_ctl with a behavioural breg model
// (mirrored low registers, SET/XOR write modes, combinational read).
`ifndef BITNESS
`define BITNESS 8
`endif
`ifndef WORD
`define WORD [`BITNESS-1:0]
`endif

module tb_breg_ctl;

  typedef struct {
    logic       port;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic `WORD val;
    int         lat;
    int         wr;
    int         wy;
    logic       err;
    logic `WORD rdata;
    logic [3:0] ci;
    logic `WORD cv;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [3:0] a0, a1, b0, b1;
  logic `WORD val0, val1;
  logic       ack0, ack1, err;
  logic `WORD rdata;
  logic [3:0] breg_ra, breg_wa;
  logic `WORD breg_rval, breg_wval, nv;
  logic       breg_w, breg_y;

  logic `WORD regs [16];

  int checks = 0;
  int passed = 0;

  breg_ctl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .val0(val0), .val1(val1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .breg_ra(breg_ra), .breg_rval(breg_rval), .breg_w(breg_w), .breg_y(breg_y),
    .breg_wa(breg_wa), .breg_wval(breg_wval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: a write to a low index also lands on index+8.
  assign nv        = breg_y ? breg_wval : (regs[breg_wa] ^ breg_wval);
  assign breg_rval = regs[breg_ra];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (breg_w) begin
      regs[breg_wa] <= nv;
      if (!breg_wa[3]) regs[{1'b1, breg_wa[2:0]}] <= nv;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic doReset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    int   n, wr, wy;
    logic got, other;
    n = 0; wr = 0; wy = 0; got = 1'b0; other = 1'b0;
    if (!v.port) begin
      op0 = v.op; a0 = v.a; b0 = v.b; val0 = v.val; req0 = 1'b1;
    end else begin
      op1 = v.op; a1 = v.a; b1 = v.b; val1 = v.val; req1 = 1'b1;
    end
    while (!got && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (breg_w) wr++;
      if (breg_w && breg_y) wy++;
      if (v.port ? ack0 : ack1) other = 1'b1;
      got = v.port ? ack1 : ack0;
    end
    checkOutput({tag, " ack"}, 32'(got), 32'd1);
    checkOutput({tag, " latency"}, n, v.lat);
    checkOutput({tag, " writes"}, wr, v.wr);
    checkOutput({tag, " set-writes"}, wy, v.wy);
    checkOutput({tag, " err"}, 32'(err), 32'(v.err));
    checkOutput({tag, " rdata"}, 32'(rdata), 32'(v.rdata));
    checkOutput({tag, " other ack"}, 32'(other), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " ack pulse"}, 32'(v.port ? ack1 : ack0), 32'd0);
    checkOutput({tag, " reg"}, 32'(regs[v.ci]), 32'(v.cv));
  endtask

  vec_t vecs [13];

  initial begin
    int seq [4];
    int k, n, first_n, bad;
    logic prev0, prev1;

    //            port  op     a      b      val    lat wr wy err   rdata  ci      cv
    vecs[0]  = '{1'b0, 2'd1, 4'd3,  4'd0,  8'hA5, 2, 1, 1, 1'b0, 8'h00, 4'd11, 8'hA5};
    vecs[1]  = '{1'b1, 2'd0, 4'd11, 4'd0,  8'h00, 2, 0, 0, 1'b0, 8'hA5, 4'd3,  8'hA5};
    vecs[2]  = '{1'b0, 2'd1, 4'd12, 4'd0,  8'hF0, 2, 1, 1, 1'b0, 8'hA5, 4'd12, 8'hF0};
    vecs[3]  = '{1'b0, 2'd2, 4'd12, 4'd0,  8'h0F, 2, 1, 0, 1'b0, 8'hA5, 4'd12, 8'hFF};
    vecs[4]  = '{1'b1, 2'd0, 4'd4,  4'd0,  8'h00, 2, 0, 0, 1'b0, 8'h00, 4'd4,  8'h00};
    vecs[5]  = '{1'b0, 2'd1, 4'd9,  4'd0,  8'h12, 2, 1, 1, 1'b0, 8'h00, 4'd9,  8'h12};
    vecs[6]  = '{1'b1, 2'd1, 4'd14, 4'd0,  8'h34, 2, 1, 1, 1'b0, 8'h00, 4'd14, 8'h34};
    vecs[7]  = '{1'b0, 2'd3, 4'd9,  4'd14, 8'h00, 4, 3, 0, 1'b0, 8'h00, 4'd9,  8'h34};
    vecs[8]  = '{1'b1, 2'd0, 4'd14, 4'd0,  8'h00, 2, 0, 0, 1'b0, 8'h12, 4'd14, 8'h12};
    vecs[9]  = '{1'b0, 2'd3, 4'd2,  4'd10, 8'h00, 1, 0, 0, 1'b1, 8'h12, 4'd3,  8'hA5};
    vecs[10] = '{1'b1, 2'd3, 4'd5,  4'd5,  8'h00, 1, 0, 0, 1'b1, 8'h12, 4'd5,  8'h00};
    vecs[11] = '{1'b0, 2'd3, 4'd3,  4'd14, 8'h00, 4, 3, 0, 1'b0, 8'h12, 4'd11, 8'h12};
    vecs[12] = '{1'b1, 2'd0, 4'd3,  4'd0,  8'h00, 2, 0, 0, 1'b0, 8'h12, 4'd14, 8'hA5};

    op0 = 2'd0; op1 = 2'd0; a0 = 4'd0; a1 = 4'd0; b0 = 4'd0; b1 = 4'd0;
    val0 = '0; val1 = '0;
    doReset();
    checkOutput("reset ack0", 32'(ack0), 32'd0);
    checkOutput("reset ack1", 32'(ack1), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset rdata", 32'(rdata), 32'd0);
    checkOutput("reset breg_w", 32'(breg_w), 32'd0);

    for (int i = 0; i < 13; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Both ports hammer SETs: grants must alternate starting with port 0.
    doReset();
    op0 = 2'd1; a0 = 4'd1; val0 = 8'h11;
    op1 = 2'd1; a1 = 4'd2; val1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    k = 0; n = 0; first_n = 0; bad = 0; prev0 = 1'b0; prev1 = 1'b0;
    while (k < 4 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if ((ack0 && ack1) || (ack0 && prev0) || (ack1 && prev1)) bad++;
      if (ack0 || ack1) begin
        if (k == 0) first_n = n;
        seq[k] = ack1 ? 1 : 0;
        k++;
      end
      prev0 = ack0;
      prev1 = ack1;
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rr ack count", k, 4);
    checkOutput("rr first latency", first_n, 2);
    checkOutput("rr bad pulses", bad, 0);
    for (int j = 0; j < 4; j++) begin
      if (j < k) checkOutput($sformatf("rr grant%0d", j), seq[j], j % 2);
    end
    @(posedge clk);
    #1;
    checkOutput("rr reg9 mirror", 32'(regs[9]), 32'h11);
    checkOutput("rr reg2", 32'(regs[2]), 32'h22);

    // Reset landing in EX2 of a SWAP aborts with no ack; a later SET still works.
    doReset();
    applyStimulus("pre0", '{1'b0, 2'd1, 4'd9,  4'd0, 8'h12, 2, 1, 1, 1'b0, 8'h00, 4'd9,  8'h12});
    applyStimulus("pre1", '{1'b0, 2'd1, 4'd14, 4'd0, 8'h34, 2, 1, 1, 1'b0, 8'h00, 4'd14, 8'h34});
    op0 = 2'd3; a0 = 4'd9; b0 = 4'd14; req0 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("swap ex1 write", 32'(breg_w), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("swap ex2 write", 32'(breg_w), 32'd1);
    rst = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort ack0", 32'(ack0), 32'd0);
    checkOutput("abort ack1", 32'(ack1), 32'd0);
    checkOutput("abort breg_w", 32'(breg_w), 32'd0);
    rst = 1'b0;
    applyStimulus("post", '{1'b1, 2'd1, 4'd5, 4'd0, 8'h5A, 2, 1, 1, 1'b0, 8'h00, 4'd13, 8'h5A});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
